// File: rtl/mux_bus_arbiter_pkg.sv
// rtl/mux_bus_arbiter_pkg.sv - shared types and constants for the round-robin bus arbiter
package mux_bus_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int N_REQ       = 8;
  localparam int SEL_W       = 3;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/mux_bus_arbiter_rr_pick.sv
// rtl/mux_bus_arbiter_rr_pick.sv - combinational round-robin pick: rotate, priority-encode, un-rotate
module rr_pick (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       valid,
  output logic [2:0] idx
);

  logic [7:0] rot;
  logic [2:0] off;

  // Rotate so that slot ptr lands at bit 0, take the lowest set bit, then map back.
  always_comb begin
    rot = (req >> ptr) | (req << (4'd8 - {1'b0, ptr}));
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off = i[2:0];
    end
    idx   = off + ptr;
    valid = |req;
  end

endmodule

// File: rtl/mux_bus_arbiter.sv
// rtl/mux_bus_arbiter.sv - round-robin arbiter for one shared 32-bit port; optional watchdog via ARB_TIMEOUT_EN
module mux_bus_arbiter
  import mux_bus_arbiter_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int TIMEOUT = DEF_TIMEOUT
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] io_req,
  input  logic             io_done,
  output logic [N_REQ-1:0] io_grant,
  output logic [SEL_W-1:0] io_sel,
  output logic             io_start,
  output logic             io_busy,
  output logic             io_timeout
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   grant_d;
  logic [SEL_W-1:0]   sel_d;
  logic               start_d, busy_d, timeout_d;
  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;
  logic               expire;

  rr_pick u_pick (
    .req   (io_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  logic [WDOG_W-1:0] wdog_q;

  // Watchdog: held at zero while idle, counts BUSY cycles that end without io_done.
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) wdog_q <= '0;
    else if (!io_done && !expire) wdog_q <= wdog_q + 1'b1;
  end

  assign expire = (state_q == BUSY) && (wdog_q == WDOG_W'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  // Next-state and registered-output values; arbitration only happens from IDLE.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = io_grant;
    sel_d     = io_sel;
    busy_d    = io_busy;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        sel_d   = '0;
        busy_d  = 1'b0;
        if (pick_valid) begin
          state_d = BUSY;
          sel_d   = pick_idx;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          busy_d  = 1'b1;
          start_d = 1'b1;
        end
      end
      BUSY: begin
        if (io_done || expire) begin
          state_d   = IDLE;
          grant_d   = '0;
          sel_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = io_sel + 3'd1;
          timeout_d = expire && !io_done;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, rotate pointer and all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      io_grant   <= '0;
      io_sel     <= '0;
      io_start   <= 1'b0;
      io_busy    <= 1'b0;
      io_timeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      io_grant   <= grant_d;
      io_sel     <= sel_d;
      io_start   <= start_d;
      io_busy    <= busy_d;
      io_timeout <= timeout_d;
    end
  end

endmodule
